// File: rtl/lsu_ctrl.sv
// Load/store controller: checks RV32I funct3/alignment, drives byte-lane memory writes and extends load data.
// Latency: store 3 cycles IDLE->IDLE, load 3+READ_LAT cycles, rejected request 2 cycles.
// Backpressure: one transaction at a time; req_ready only in IDLE, response held until resp_ready.
module lsu_ctrl #(
  parameter int READ_LAT = 1,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic [3:0]        mem_we,
  input  logic [31:0]       mem_dout
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  // Final WAIT count value; with READ_LAT=0 the WAIT state is never entered.
  localparam logic [1:0] LAST_CNT = (READ_LAT > 0) ? 2'(READ_LAT - 1) : 2'd0;

  state_t            state_q, state_d;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic [1:0]        cnt_q;

  logic              accept;
  logic              req_legal;
  logic              req_misaligned;
  logic              req_err;
  logic              capture;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [31:0]       load_v;
  logic [31:0]       din_v;
  logic [3:0]        be_v;

  assign accept = req_valid & req_ready;

  // Legality and alignment of the incoming request, evaluated before it is latched.
  always_comb begin
    req_legal = 1'b0;
    if (req_we) begin
      req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    end else begin
      req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                  (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
    end
    req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    req_err = !req_legal || req_misaligned;
  end

  // State register; reset drops any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state sequencing: rejected requests skip the memory entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = req_err ? RESP : ACCESS;
      ACCESS:  state_d = (!we_q && (READ_LAT != 0)) ? WAIT : RESP;
      WAIT:    if (cnt_q == LAST_CNT) state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Load data is sampled in ACCESS for a zero-latency memory, else on the last WAIT cycle.
  assign capture = ((state_q == ACCESS) && !we_q && (READ_LAT == 0)) ||
                   ((state_q == WAIT) && (cnt_q == LAST_CNT));

  // Request latch, wait counter and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      cnt_q   <= 2'd0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= req_err;
        rdata_q <= 32'd0;
      end
      if (state_q == ACCESS)    cnt_q <= 2'd0;
      else if (state_q == WAIT) cnt_q <= cnt_q + 2'd1;
      if (capture) rdata_q <= load_v;
    end
  end

  // Pick the addressed byte/half from the read word and extend it per funct3.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    byte_v = mem_dout[7:0];
      2'd1:    byte_v = mem_dout[15:8];
      2'd2:    byte_v = mem_dout[23:16];
      default: byte_v = mem_dout[31:24];
    endcase
    half_v = addr_q[1] ? mem_dout[31:16] : mem_dout[15:0];
    case (f3_q)
      3'b000:  load_v = {{24{byte_v[7]}}, byte_v};
      3'b100:  load_v = {24'd0, byte_v};
      3'b001:  load_v = {{16{half_v[15]}}, half_v};
      3'b101:  load_v = {16'd0, half_v};
      3'b010:  load_v = mem_dout;
      default: load_v = 32'd0;
    endcase
  end

  // Replicate store data across lanes and enable only the addressed bytes.
  always_comb begin
    case (f3_q)
      3'b000: begin
        din_v = {4{wdata_q[7:0]}};
        be_v  = 4'b0001 << addr_q[1:0];
      end
      3'b001: begin
        din_v = {2{wdata_q[15:0]}};
        be_v  = 4'b0011 << addr_q[1:0];
      end
      3'b010: begin
        din_v = wdata_q;
        be_v  = 4'b1111;
      end
      default: begin
        din_v = 32'd0;
        be_v  = 4'b0000;
      end
    endcase
  end

  // Output decode; write enables exist only in ACCESS so an abort cannot leave a late write.
  always_comb begin
    req_ready  = (state_q == IDLE) && !rst;
    resp_valid = (state_q == RESP);
    resp_rdata = rdata_q;
    resp_err   = err_q;
    mem_addr   = ((state_q == ACCESS) || (state_q == WAIT)) ? addr_q : '0;
    mem_din    = ((state_q == ACCESS) && we_q) ? din_v : 32'd0;
    mem_we     = ((state_q == ACCESS) && we_q) ? be_v : 4'b0000;
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_ready;
  logic [1:0]  sel;

  logic [2:0]  vld_v;
  logic [2:0]  rdy_v;
  logic [2:0]  rv_v;
  logic [2:0]  er_v;
  logic [31:0] rd_a    [3];
  logic [31:0] maddr_a [3];
  logic [31:0] mdin_a  [3];
  logic [3:0]  mwe_a   [3];
  logic [31:0] mdout_a [3];

  logic        cur_rdy, cur_rv, cur_er;
  logic [31:0] cur_rd;

  logic [31:0] mem [0:63];
  logic [31:0] p1;
  logic [31:0] p3 [3];
  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_val;
  int          we_cnt = 0;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // DUT 0: READ_LAT=1 (main), DUT 1: READ_LAT=0, DUT 2: READ_LAT=3
  assign vld_v = {req_valid && (sel == 2'd2), req_valid && (sel == 2'd1), req_valid && (sel == 2'd0)};

  lsu_ctrl #(.READ_LAT(1), .ADDR_W(32)) u_dut (
    .clk(clk), .rst(rst), .req_valid(vld_v[0]), .req_ready(rdy_v[0]), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv_v[0]),
    .resp_ready(resp_ready), .resp_rdata(rd_a[0]), .resp_err(er_v[0]), .mem_addr(maddr_a[0]),
    .mem_din(mdin_a[0]), .mem_we(mwe_a[0]), .mem_dout(mdout_a[0]));

  lsu_ctrl #(.READ_LAT(0), .ADDR_W(32)) u_dut_l0 (
    .clk(clk), .rst(rst), .req_valid(vld_v[1]), .req_ready(rdy_v[1]), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv_v[1]),
    .resp_ready(resp_ready), .resp_rdata(rd_a[1]), .resp_err(er_v[1]), .mem_addr(maddr_a[1]),
    .mem_din(mdin_a[1]), .mem_we(mwe_a[1]), .mem_dout(mdout_a[1]));

  lsu_ctrl #(.READ_LAT(3), .ADDR_W(32)) u_dut_l3 (
    .clk(clk), .rst(rst), .req_valid(vld_v[2]), .req_ready(rdy_v[2]), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv_v[2]),
    .resp_ready(resp_ready), .resp_rdata(rd_a[2]), .resp_err(er_v[2]), .mem_addr(maddr_a[2]),
    .mem_din(mdin_a[2]), .mem_we(mwe_a[2]), .mem_dout(mdout_a[2]));

  always_comb begin
    cur_rdy = rdy_v[sel];
    cur_rv  = rv_v[sel];
    cur_er  = er_v[sel];
    cur_rd  = rd_a[sel];
  end

  // Byte-enabled memory (writes from the main DUT) with per-DUT read latency pipelines
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (mwe_a[0][b]) mem[maddr_a[0][7:2]][8*b +: 8] <= mdin_a[0][8*b +: 8];
    if (pl_en) mem[pl_idx] <= pl_val;
    p1    <= maddr_a[0];
    p3[0] <= maddr_a[2];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  assign mdout_a[0] = mem[p1[7:2]];
  assign mdout_a[1] = mem[maddr_a[1][7:2]];
  assign mdout_a[2] = mem[p3[2][7:2]];

  always @(negedge clk) if (mwe_a[0] != 4'b0000) we_cnt <= we_cnt + 1;

  task automatic preload(input logic [5:0] idx, input logic [31:0] val);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Present a request and return on the negedge after it is accepted
  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int n = 0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    while (!cur_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cur_rdy) begin
      checks++; failures++;
      $display("FAIL send_accept: req_ready=%0b required 1 within 50 cycles", cur_rdy);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Wait for a response, take it with resp_ready=1, return the observed values
  task automatic collect(output logic [31:0] rd, output logic e);
    int n = 0;
    resp_ready = 1'b1;
    while (!cur_rv && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cur_rv) begin
      checks++; failures++;
      $display("FAIL collect_resp: resp_valid=%0b required 1 within 50 cycles", cur_rv);
    end
    rd = cur_rd;
    e  = cur_er;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b1; sel = 2'd0; pl_en = 1'b0;
    req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    checks++; if (rdy_v !== 3'b000) begin failures++; $display("FAIL rst_req_ready: got %b required 000", rdy_v); end
    checks++; if (rv_v !== 3'b000) begin failures++; $display("FAIL rst_resp_valid: got %b required 000", rv_v); end
    checks++; if (er_v !== 3'b000) begin failures++; $display("FAIL rst_resp_err: got %b required 000", er_v); end
    checks++; if (mwe_a[0] !== 4'b0000) begin failures++; $display("FAIL rst_mem_we: got %b required 0000", mwe_a[0]); end
    checks++; if ({rd_a[0], maddr_a[0], mdin_a[0]} !== 96'd0) begin
      failures++; $display("FAIL rst_data: rdata=%h addr=%h din=%h required all 0", rd_a[0], maddr_a[0], mdin_a[0]);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (rdy_v !== 3'b111) begin failures++; $display("FAIL rst_release_ready: got %b required 111", rdy_v); end
  endtask

  task automatic test_store();
    logic [31:0] rd; logic e; exp_t x;
    sel = 2'd0;
    exp_q.push_back('{32'd0, 1'b0});
    send(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    checks++; if (mwe_a[0] !== 4'b1111 || mdin_a[0] !== 32'hDEADBEEF || maddr_a[0] !== 32'h10) begin
      failures++; $display("FAIL sw_access: we=%b din=%h addr=%h required 1111 deadbeef 00000010", mwe_a[0], mdin_a[0], maddr_a[0]);
    end
    collect(rd, e); x = exp_q.pop_front();
    checks++; if (rd !== x.rdata || e !== x.err) begin failures++; $display("FAIL sw_resp: rdata=%h err=%b required %h %b", rd, e, x.rdata, x.err); end

    exp_q.push_back('{32'd0, 1'b0});
    send(1'b1, 3'b000, 32'h13, 32'h000000A5);
    checks++; if (mwe_a[0] !== 4'b1000 || mdin_a[0] !== 32'hA5A5A5A5 || maddr_a[0] !== 32'h13) begin
      failures++; $display("FAIL sb_access: we=%b din=%h addr=%h required 1000 a5a5a5a5 00000013", mwe_a[0], mdin_a[0], maddr_a[0]);
    end
    collect(rd, e); x = exp_q.pop_front();
    checks++; if (rd !== x.rdata || e !== x.err) begin failures++; $display("FAIL sb_resp: rdata=%h err=%b required %h %b", rd, e, x.rdata, x.err); end

    exp_q.push_back('{32'hA5ADBEEF, 1'b0});
    send(1'b0, 3'b010, 32'h10, 32'd0);
    collect(rd, e); x = exp_q.pop_front();
    checks++; if (rd !== x.rdata || e !== x.err) begin failures++; $display("FAIL lw_after_sb: rdata=%h err=%b required %h %b", rd, e, x.rdata, x.err); end
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3 [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
    logic [31:0] ad [6] = '{32'h12, 32'h13, 32'h12, 32'h10, 32'h10, 32'h11};
    logic [31:0] ex [6] = '{32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF, 32'h00007F01, 32'h80FF7F01, 32'h0000007F};
    logic [31:0] rd; logic e; exp_t x;
    sel = 2'd0;
    preload(6'd4, 32'h80FF7F01);
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back('{ex[i], 1'b0});
      send(1'b0, f3[i], ad[i], 32'd0);
      collect(rd, e); x = exp_q.pop_front();
      checks++; if (rd !== x.rdata || e !== x.err) begin
        failures++; $display("FAIL load_ext[%0d]: rdata=%h err=%b required %h %b", i, rd, e, x.rdata, x.err);
      end
    end
  endtask

  task automatic test_errors();
    logic        we [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f3 [5] = '{3'b010, 3'b001, 3'b011, 3'b100, 3'b101};
    logic [31:0] ad [5] = '{32'h11, 32'h03, 32'h10, 32'h10, 32'h13};
    logic [31:0] rd; logic e; exp_t x; int start;
    sel = 2'd0;
    start = we_cnt;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back('{32'd0, 1'b1});
      send(we[i], f3[i], ad[i], 32'hCAFEF00D);
      collect(rd, e); x = exp_q.pop_front();
      checks++; if (rd !== x.rdata || e !== x.err) begin
        failures++; $display("FAIL err_resp[%0d]: rdata=%h err=%b required %h %b", i, rd, e, x.rdata, x.err);
      end
    end
    checks++; if (we_cnt !== start) begin failures++; $display("FAIL err_no_write: mem_we active %0d cycles required 0", we_cnt - start); end
  endtask

  task automatic test_backpressure();
    exp_t x; int n = 0;
    sel = 2'd0;
    resp_ready = 1'b0;
    exp_q.push_back('{32'h80FF7F01, 1'b0});
    send(1'b0, 3'b010, 32'h10, 32'd0);
    while (!cur_rv && n < 20) begin
      @(negedge clk);
      n++;
    end
    x = exp_q.pop_front();
    for (int c = 0; c < 5; c++) begin
      checks++; if (cur_rv !== 1'b1 || cur_rd !== x.rdata || cur_er !== x.err || cur_rdy !== 1'b0) begin
        failures++; $display("FAIL hold[%0d]: valid=%b rdata=%h err=%b ready=%b required 1 %h %b 0", c, cur_rv, cur_rd, cur_er, cur_rdy, x.rdata, x.err);
      end
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    checks++; if (cur_rdy !== 1'b1 || cur_rv !== 1'b0) begin
      failures++; $display("FAIL hold_release: ready=%b valid=%b required 1 0", cur_rdy, cur_rv);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  sl [4] = '{2'd1, 2'd0, 2'd2, 2'd0};
    logic        we [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] ex [4] = '{32'h13579BDF, 32'h13579BDF, 32'h13579BDF, 32'd0};
    int          lat [4] = '{3, 4, 6, 3};
    logic [31:0] rd; logic e; logic got; exp_t x; int n;
    resp_ready = 1'b1;
    preload(6'd5, 32'h13579BDF);
    for (int i = 0; i < 4; i++) begin
      sel = sl[i];
      exp_q.push_back('{ex[i], 1'b0});
      send(we[i], 3'b010, we[i] ? 32'h18 : 32'h14, 32'h2468ACE0);
      n = 1; got = 1'b0; rd = 32'hX; e = 1'bX;
      while (!cur_rdy && n < 30) begin
        if (cur_rv) begin rd = cur_rd; e = cur_er; got = 1'b1; end
        @(negedge clk);
        n++;
      end
      x = exp_q.pop_front();
      checks++; if (n !== lat[i]) begin failures++; $display("FAIL turnaround[%0d]: %0d cycles required %0d", i, n, lat[i]); end
      checks++; if (got !== 1'b1 || rd !== x.rdata || e !== x.err) begin
        failures++; $display("FAIL turnaround_data[%0d]: seen=%b rdata=%h err=%b required 1 %h %b", i, got, rd, e, x.rdata, x.err);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic e; exp_t x;
    sel = 2'd0;
    send(1'b1, 3'b010, 32'h20, 32'h11223344);
    checks++; if (mwe_a[0] !== 4'b1111) begin failures++; $display("FAIL abort_access: we=%b required 1111", mwe_a[0]); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (mwe_a[0] !== 4'b0000 || rv_v[0] !== 1'b0 || rdy_v[0] !== 1'b0) begin
      failures++; $display("FAIL abort_state: we=%b valid=%b ready=%b required 0000 0 0", mwe_a[0], rv_v[0], rdy_v[0]);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (rdy_v[0] !== 1'b1 || rv_v[0] !== 1'b0) begin
      failures++; $display("FAIL abort_idle: ready=%b valid=%b required 1 0", rdy_v[0], rv_v[0]);
    end
    exp_q.push_back('{32'd0, 1'b0});
    send(1'b1, 3'b010, 32'h20, 32'h55667788);
    checks++; if (mwe_a[0] !== 4'b1111 || mdin_a[0] !== 32'h55667788) begin
      failures++; $display("FAIL post_abort_sw: we=%b din=%h required 1111 55667788", mwe_a[0], mdin_a[0]);
    end
    collect(rd, e); x = exp_q.pop_front();
    checks++; if (rd !== x.rdata || e !== x.err) begin failures++; $display("FAIL post_abort_resp: rdata=%h err=%b required %h %b", rd, e, x.rdata, x.err); end
    exp_q.push_back('{32'h55667788, 1'b0});
    send(1'b0, 3'b010, 32'h20, 32'd0);
    collect(rd, e); x = exp_q.pop_front();
    checks++; if (rd !== x.rdata || e !== x.err) begin failures++; $display("FAIL post_abort_lw: rdata=%h err=%b required %h %b", rd, e, x.rdata, x.err); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_left: %0d entries required 0", exp_q.size()); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_store();
    test_load_ext();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
